// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register-index types, MEM-stage FSM states, PC increment.
package cpu_types_pkg;

   localparam int WORD_BITS = 32;
   localparam int REG_BITS  = 5;

   typedef logic [WORD_BITS-1:0] word_t;
   typedef logic [REG_BITS-1:0]  regbits_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } mem_state_t;

   localparam word_t PC_INC = word_t'(4);

endpackage

// File: rtl/mem_wb_sel.sv
// Writeback value mux for the MEM stage: load data, link address, LUI, AUIPC or ALU result.
module mem_wb_sel
   import cpu_types_pkg::*;
(
   input  logic  memtoreg,
   input  logic  jal,
   input  logic  jalr,
   input  logic  lui,
   input  logic  auipc,
   input  logic  dhit,
   input  word_t dmemload,
   input  word_t load_buf,
   input  word_t imemaddr,
   input  word_t imm,
   input  word_t presult,
   output word_t wdat
);

   always_comb begin
      wdat = presult;
      if (memtoreg) begin
         // Zero-wait hit has not reached load_buf yet, so bypass it.
         wdat = dhit ? dmemload : load_buf;
      end else if (jal | jalr) begin
         wdat = imemaddr + PC_INC;
      end else if (lui) begin
         wdat = imm;
      end else if (auipc) begin
         wdat = imemaddr + imm;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-cache handshake, pipeline stall, writeback select and MEM/WB latch.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned accesses into a halting trap.
module mem_stage_ctrl
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              pipe_en,
   input  logic              flush,
   input  logic              dmemr_mem,
   input  logic              dmemw_mem,
   input  logic              WEN_mem,
   input  logic              memtoreg_mem,
   input  logic              jal_mem,
   input  logic              jalr_mem,
   input  logic              lui_mem,
   input  logic              auipc_mem,
   input  logic              halt_mem,
   input  logic [WORD_W-1:0] imemaddr_mem,
   input  logic [WORD_W-1:0] imemload_mem,
   input  logic [WORD_W-1:0] presult_mem,
   input  logic [WORD_W-1:0] imm_mem,
   input  logic [WORD_W-1:0] dmemstore,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore_out,
   output logic              mem_busy,
   output logic [WORD_W-1:0] wdat_wb,
   output logic [REG_AW-1:0] rd_wb,
   output logic              WEN_wb,
   output logic              halt_wb
);

   mem_state_t        state_reg, state_next;
   word_t             load_buf_reg;
   word_t             wdat_sel;
   logic [WORD_W-1:0] wdat_wb_reg;
   logic [REG_AW-1:0] rd_wb_reg;
   logic              wen_wb_reg;
   logic              halt_wb_reg;
   logic              misalign;
   logic              access_ok;
   logic              wb_load;
   logic [WORD_W-REG_AW-1:0] unused_imem;

   assign unused_imem = {imemload_mem[WORD_W-1:7+REG_AW], imemload_mem[6:0]};

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = (presult_mem[1:0] != 2'b00) & (dmemr_mem | dmemw_mem);
`else
   assign misalign = 1'b0;
`endif

   assign access_ok = !flush & !misalign & ((state_reg == IDLE) | (state_reg == WAIT));
   assign dmemREN   = dmemr_mem & access_ok;
   assign dmemWEN   = dmemw_mem & access_ok;
   assign mem_busy  = (dmemREN | dmemWEN) & !dhit;
   assign wb_load   = pipe_en & !mem_busy;

   assign dmemaddr      = presult_mem;
   assign dmemstore_out = dmemstore;

   // DONE parks a completed access only while the pipe is stalled; if the
   // instruction leaves in the completion cycle the next one must start in IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (!flush && misalign) begin
               state_next = pipe_en ? IDLE : DONE;
            end else if (!flush && (dmemr_mem || dmemw_mem)) begin
               if (dhit) state_next = pipe_en ? IDLE : DONE;
               else      state_next = WAIT;
            end
         end
         WAIT: begin
            if (flush)     state_next = IDLE;
            else if (dhit) state_next = pipe_en ? IDLE : DONE;
         end
         DONE: begin
            if (pipe_en || flush) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   mem_wb_sel u_wb_sel (
      .memtoreg (memtoreg_mem),
      .jal      (jal_mem),
      .jalr     (jalr_mem),
      .lui      (lui_mem),
      .auipc    (auipc_mem),
      .dhit     (dhit),
      .dmemload (dmemload),
      .load_buf (load_buf_reg),
      .imemaddr (imemaddr_mem),
      .imm      (imm_mem),
      .presult  (presult_mem),
      .wdat     (wdat_sel)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= IDLE;
         load_buf_reg <= '0;
         wdat_wb_reg  <= '0;
         rd_wb_reg    <= '0;
         wen_wb_reg   <= 1'b0;
         halt_wb_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (dhit & dmemr_mem) begin
            load_buf_reg <= dmemload;
         end
         if (wb_load) begin
            if (flush) begin
               // Bubble: data/rd kept, halt stays sticky.
               wen_wb_reg <= 1'b0;
            end else begin
               wdat_wb_reg <= wdat_sel;
               rd_wb_reg   <= imemload_mem[7 +: REG_AW];
               wen_wb_reg  <= WEN_mem & !misalign;
               halt_wb_reg <= halt_wb_reg | halt_mem | misalign;
            end
         end
      end
   end

   assign wdat_wb = wdat_wb_reg;
   assign rd_wb   = rd_wb_reg;
   assign WEN_wb  = wen_wb_reg;
   assign halt_wb = halt_wb_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl: writeback table plus handshake sequences.
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-load case.
module tb_mem_stage_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        pipe_en, flush, dmemr_mem, dmemw_mem;
   logic        WEN_mem, memtoreg_mem, jal_mem, jalr_mem, lui_mem, auipc_mem, halt_mem;
   logic [31:0] imemaddr_mem, imemload_mem, presult_mem, imm_mem, dmemstore;
   logic        dhit;
   logic [31:0] dmemload;
   logic        dmemREN, dmemWEN, mem_busy, WEN_wb, halt_wb;
   logic [31:0] dmemaddr, dmemstore_out, wdat_wb;
   logic [4:0]  rd_wb;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   mem_stage_ctrl #(.WORD_W(32), .REG_AW(5)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .pipe_en       (pipe_en),
      .flush         (flush),
      .dmemr_mem     (dmemr_mem),
      .dmemw_mem     (dmemw_mem),
      .WEN_mem       (WEN_mem),
      .memtoreg_mem  (memtoreg_mem),
      .jal_mem       (jal_mem),
      .jalr_mem      (jalr_mem),
      .lui_mem       (lui_mem),
      .auipc_mem     (auipc_mem),
      .halt_mem      (halt_mem),
      .imemaddr_mem  (imemaddr_mem),
      .imemload_mem  (imemload_mem),
      .presult_mem   (presult_mem),
      .imm_mem       (imm_mem),
      .dmemstore     (dmemstore),
      .dhit          (dhit),
      .dmemload      (dmemload),
      .dmemREN       (dmemREN),
      .dmemWEN       (dmemWEN),
      .dmemaddr      (dmemaddr),
      .dmemstore_out (dmemstore_out),
      .mem_busy      (mem_busy),
      .wdat_wb       (wdat_wb),
      .rd_wb         (rd_wb),
      .WEN_wb        (WEN_wb),
      .halt_wb       (halt_wb)
   );

   typedef struct {
      logic        jal, jalr, lui, auipc, wen, flush;
      logic [31:0] pc, presult, imm;
      logic [4:0]  rd;
      logic [31:0] exp_wdat;
      logic [4:0]  exp_rd;
      logic        exp_wen;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk(input logic jal, input logic jalr, input logic lui,
                               input logic auipc, input logic wen, input logic fl,
                               input logic [31:0] pc, input logic [31:0] presult,
                               input logic [31:0] imm, input logic [4:0] rd,
                               input logic [31:0] exp_wdat, input logic [4:0] exp_rd,
                               input logic exp_wen);
      vec_t v;
      v.jal = jal; v.jalr = jalr; v.lui = lui; v.auipc = auipc; v.wen = wen; v.flush = fl;
      v.pc = pc; v.presult = presult; v.imm = imm; v.rd = rd;
      v.exp_wdat = exp_wdat; v.exp_rd = exp_rd; v.exp_wen = exp_wen;
      return v;
   endfunction

   function automatic logic [31:0] instr(input logic [4:0] rd);
      return {20'hABCDE, rd, 7'h33};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      pipe_en = 1'b0; flush = 1'b0; dmemr_mem = 1'b0; dmemw_mem = 1'b0;
      WEN_mem = 1'b0; memtoreg_mem = 1'b0; jal_mem = 1'b0; jalr_mem = 1'b0;
      lui_mem = 1'b0; auipc_mem = 1'b0; halt_mem = 1'b0;
      imemaddr_mem = '0; imemload_mem = '0; presult_mem = '0; imm_mem = '0;
      dmemstore = '0; dhit = 1'b0; dmemload = '0;
   endtask

   task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
      idle_inputs();
      dmemr_mem = 1'b1; memtoreg_mem = 1'b1; WEN_mem = 1'b1;
      presult_mem = addr; imemload_mem = instr(rd); pipe_en = 1'b1;
   endtask

   task automatic set_alu(input logic [31:0] res, input logic [4:0] rd,
                          input logic wen, input logic halt);
      idle_inputs();
      presult_mem = res; imemload_mem = instr(rd); WEN_mem = wen;
      halt_mem = halt; pipe_en = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = mk(0,0,0,0, 1,0, 32'h0000_0000, 32'hA5A5_0001, 32'h0,         5'd3,  32'hA5A5_0001, 5'd3,  1);
      vecs[1] = mk(1,0,0,0, 1,0, 32'h0000_0FFC, 32'h0,         32'h0,         5'd1,  32'h0000_1000, 5'd1,  1);
      vecs[2] = mk(0,1,0,0, 1,0, 32'hFFFF_FFFC, 32'h0,         32'h0,         5'd2,  32'h0000_0000, 5'd2,  1);
      vecs[3] = mk(0,0,1,1, 1,0, 32'h0000_0040, 32'h0,         32'h1234_5000, 5'd4,  32'h1234_5000, 5'd4,  1);
      vecs[4] = mk(0,0,0,1, 1,0, 32'h0000_2000, 32'h0,         32'hFFFF_F000, 5'd6,  32'h0000_1000, 5'd6,  1);
      vecs[5] = mk(1,0,1,0, 1,0, 32'h0000_0080, 32'h0,         32'hABC0_0000, 5'd8,  32'h0000_0084, 5'd8,  1);
      vecs[6] = mk(0,0,0,0, 1,1, 32'h0000_0000, 32'h0000_0055, 32'h0,         5'd9,  32'h0000_0084, 5'd8,  0);
      vecs[7] = mk(0,0,0,0, 0,0, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         5'd10, 32'h0BAD_F00D, 5'd10, 0);

      // Reset state
      idle_inputs();
      nRST = 1'b0;
      #3;
      chk("rst_wdat", wdat_wb, 32'h0);
      chk("rst_rd", 32'(rd_wb), 32'h0);
      chk("rst_wen", 32'(WEN_wb), 32'h0);
      chk("rst_halt", 32'(halt_wb), 32'h0);
      chk("rst_ren", 32'(dmemREN), 32'h0);
      chk("rst_busy", 32'(mem_busy), 32'h0);
      $display("txn reset checked");
      nRST = 1'b1;
      tick();

      // Single-cycle writeback table
      for (int i = 0; i < 8; i++) begin
         idle_inputs();
         jal_mem = vecs[i].jal; jalr_mem = vecs[i].jalr; lui_mem = vecs[i].lui;
         auipc_mem = vecs[i].auipc; WEN_mem = vecs[i].wen; flush = vecs[i].flush;
         imemaddr_mem = vecs[i].pc; presult_mem = vecs[i].presult; imm_mem = vecs[i].imm;
         imemload_mem = instr(vecs[i].rd); pipe_en = 1'b1;
         #1;
         chk($sformatf("row%0d_busy", i), 32'(mem_busy), 32'h0);
         tick();
         chk($sformatf("row%0d_wdat", i), wdat_wb, vecs[i].exp_wdat);
         chk($sformatf("row%0d_rd", i), 32'(rd_wb), 32'(vecs[i].exp_rd));
         chk($sformatf("row%0d_wen", i), 32'(WEN_wb), 32'(vecs[i].exp_wen));
         $display("txn row %0d wdat_wb=%h rd_wb=%0d WEN_wb=%0b", i, wdat_wb, rd_wb, WEN_wb);
      end

      // Load with 3-cycle miss
      set_load(32'h100, 5'd5);
      for (int c = 1; c <= 2; c++) begin
         #1;
         chk($sformatf("miss_c%0d_ren", c), 32'(dmemREN), 32'h1);
         chk($sformatf("miss_c%0d_busy", c), 32'(mem_busy), 32'h1);
         chk($sformatf("miss_c%0d_addr", c), dmemaddr, 32'h100);
         tick();
         chk($sformatf("miss_c%0d_hold_wen", c), 32'(WEN_wb), 32'h0);
         chk($sformatf("miss_c%0d_hold_wdat", c), wdat_wb, 32'h0BAD_F00D);
      end
      dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
      #1;
      chk("miss_c3_ren", 32'(dmemREN), 32'h1);
      chk("miss_c3_busy", 32'(mem_busy), 32'h0);
      tick();
      chk("miss_wdat", wdat_wb, 32'hDEAD_BEEF);
      chk("miss_rd", 32'(rd_wb), 32'd5);
      chk("miss_wen", 32'(WEN_wb), 32'h1);
      $display("txn load miss wdat_wb=%h", wdat_wb);

      // Zero-wait load while stalled: DONE must not reissue, writeback from load_buf
      set_load(32'h200, 5'd11);
      pipe_en = 1'b0; dhit = 1'b1; dmemload = 32'hCAFE_F00D;
      #1;
      chk("buf_ren", 32'(dmemREN), 32'h1);
      chk("buf_busy", 32'(mem_busy), 32'h0);
      tick();
      chk("buf_stall_wdat", wdat_wb, 32'hDEAD_BEEF);
      dhit = 1'b0; dmemload = 32'h1111_1111;
      #1;
      chk("buf_done_ren", 32'(dmemREN), 32'h0);
      chk("buf_done_busy", 32'(mem_busy), 32'h0);
      tick();
      pipe_en = 1'b1;
      #1;
      chk("buf_adv_ren", 32'(dmemREN), 32'h0);
      tick();
      chk("buf_wdat", wdat_wb, 32'hCAFE_F00D);
      chk("buf_rd", 32'(rd_wb), 32'd11);
      $display("txn buffered load wdat_wb=%h", wdat_wb);

      // Zero-wait store
      idle_inputs();
      dmemw_mem = 1'b1; dmemstore = 32'h1234_5678; presult_mem = 32'h300;
      imemload_mem = instr(5'd12); dhit = 1'b1; pipe_en = 1'b1;
      #1;
      chk("st_wen_strobe", 32'(dmemWEN), 32'h1);
      chk("st_ren_strobe", 32'(dmemREN), 32'h0);
      chk("st_busy", 32'(mem_busy), 32'h0);
      chk("st_addr", dmemaddr, 32'h300);
      chk("st_data", dmemstore_out, 32'h1234_5678);
      tick();
      chk("st_wen_wb", 32'(WEN_wb), 32'h0);
      idle_inputs();
      #1;
      chk("st_strobe_drop", 32'(dmemWEN), 32'h0);
      $display("txn store addr=%h", 32'h300);

      // Flush during WAIT with simultaneous dhit
      set_alu(32'h77, 5'd7, 1'b1, 1'b0);
      tick();
      chk("fl_prime_wen", 32'(WEN_wb), 32'h1);
      set_load(32'h400, 5'd13);
      #1;
      chk("fl_wait_busy", 32'(mem_busy), 32'h1);
      tick();
      flush = 1'b1; dhit = 1'b1; dmemload = 32'h99;
      #1;
      chk("fl_ren", 32'(dmemREN), 32'h0);
      chk("fl_busy", 32'(mem_busy), 32'h0);
      tick();
      chk("fl_wen_wb", 32'(WEN_wb), 32'h0);
      chk("fl_wdat_kept", wdat_wb, 32'h77);
      chk("fl_rd_kept", 32'(rd_wb), 32'd7);
      set_load(32'h500, 5'd14);
      #1;
      chk("fl_next_ren", 32'(dmemREN), 32'h1);
      chk("fl_next_busy", 32'(mem_busy), 32'h1);
      tick();
      dhit = 1'b1; dmemload = 32'h5555_AAAA;
      tick();
      chk("fl_next_wdat", wdat_wb, 32'h5555_AAAA);
      chk("fl_next_rd", 32'(rd_wb), 32'd14);
      $display("txn flush in WAIT, follow-up load wdat_wb=%h", wdat_wb);

      // Misaligned load
      set_load(32'h102, 5'd15);
`ifdef MEM_MISALIGN_TRAP_EN
      #1;
      chk("mis_ren", 32'(dmemREN), 32'h0);
      chk("mis_busy", 32'(mem_busy), 32'h0);
      tick();
      chk("mis_halt", 32'(halt_wb), 32'h1);
      chk("mis_wen", 32'(WEN_wb), 32'h0);
`else
      #1;
      chk("mis_ren", 32'(dmemREN), 32'h1);
      chk("mis_addr", dmemaddr, 32'h102);
      chk("mis_busy", 32'(mem_busy), 32'h1);
      tick();
      dhit = 1'b1; dmemload = 32'h0F0F_0F0F;
      tick();
      chk("mis_wdat", wdat_wb, 32'h0F0F_0F0F);
      chk("mis_wen", 32'(WEN_wb), 32'h1);
      chk("mis_halt", 32'(halt_wb), 32'h0);
`endif
      $display("txn misaligned load halt_wb=%0b WEN_wb=%0b", halt_wb, WEN_wb);

      // Sticky halt
      set_alu(32'h1, 5'd16, 1'b1, 1'b1);
      tick();
      chk("halt_set", 32'(halt_wb), 32'h1);
      set_alu(32'h2, 5'd17, 1'b1, 1'b0);
      tick();
      chk("halt_sticky", 32'(halt_wb), 32'h1);
      flush = 1'b1;
      tick();
      chk("halt_sticky_flush", 32'(halt_wb), 32'h1);
      $display("txn sticky halt halt_wb=%0b", halt_wb);

      // Asynchronous reset mid-WAIT
      set_load(32'h600, 5'd18);
      tick();
      #1;
      chk("rw_wait_busy", 32'(mem_busy), 32'h1);
      #1;
      nRST = 1'b0;
      idle_inputs();
      #1;
      chk("rw_wdat", wdat_wb, 32'h0);
      chk("rw_rd", 32'(rd_wb), 32'h0);
      chk("rw_wen", 32'(WEN_wb), 32'h0);
      chk("rw_halt", 32'(halt_wb), 32'h0);
      chk("rw_ren", 32'(dmemREN), 32'h0);
      chk("rw_busy", 32'(mem_busy), 32'h0);
      tick();
      nRST = 1'b1;
      #1;
      chk("rw_release_ren", 32'(dmemREN), 32'h0);
      tick();
      chk("rw_idle_ren", 32'(dmemREN), 32'h0);
      // memtoreg without an access writes back load_buf, which reset must have cleared
      idle_inputs();
      memtoreg_mem = 1'b1; WEN_mem = 1'b1; imemload_mem = instr(5'd19); pipe_en = 1'b1;
      tick();
      chk("rw_loadbuf", wdat_wb, 32'h0);
      chk("rw_after_rd", 32'(rd_wb), 32'd19);
      chk("rw_after_wen", 32'(WEN_wb), 32'h1);
      $display("txn reset mid-WAIT");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
